// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer state encoding, MAR/MDR source selects, RW polarity and default memory-wait timeout
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_F_ADDR, S_F_WAIT, S_DECODE, S_EXEC, S_M_ADDR, S_M_WAIT, S_WBACK, S_ERROR
  } state_e;
  localparam logic MAR_PC      = 1'b0;
  localparam logic MAR_ALU     = 1'b1;
  localparam logic MDR_MEM     = 1'b0;
  localparam logic MDR_RF      = 1'b1;
  localparam logic RW_READ     = 1'b1;
  localparam logic RW_WRITE    = 1'b0;
  localparam int   TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 8-bit wait counter (clk, rst, clr, en in; expired out, high during the LIMIT-th counted wait cycle)
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
  assign expired = cnt_q == LAST;
endmodule

// File: rtl/cpu_mem_sequencer.sv
// cpu_mem_sequencer: fetch/execute FSM (CLK, RST, start, decoder flags, MOC in; MFA/RW handshake, register load enables, selects, pc_inc, rf_we, busy, err out)
module cpu_mem_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic is_load,
  input  logic is_store,
  input  logic cond_pass,
  input  logic s_bit,
  input  logic MOC,
  output logic MFA,
  output logic RW,
  output logic IRLd,
  output logic MARLd,
  output logic MDRLd,
  output logic FDRLd,
  output logic mar_sel,
  output logic mdr_sel,
  output logic pc_inc,
  output logic rf_we,
  output logic busy,
  output logic err
);
  state_e state_q, state_d, nxt;
  logic op_is_load_q, op_is_load_d, expired, in_wait;
  assign in_wait = state_q == S_F_WAIT || state_q == S_M_WAIT;
  assign nxt = start ? S_F_ADDR : S_IDLE;
  mem_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk(CLK),
    .rst(RST),
    .clr(state_q == S_F_ADDR || state_q == S_M_ADDR),
    .en(in_wait && !MOC),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    op_is_load_d = op_is_load_q;
    unique case (state_q)
      S_IDLE:   state_d = nxt;
      S_F_ADDR: state_d = S_F_WAIT;
      S_F_WAIT: state_d = MOC ? S_DECODE : expired ? S_ERROR : S_F_WAIT;
      S_DECODE: begin
        op_is_load_d = is_load;
        state_d = !cond_pass ? nxt : (is_load || is_store) ? S_M_ADDR : S_EXEC;
      end
      S_EXEC, S_WBACK: state_d = nxt;
      S_M_ADDR: state_d = S_M_WAIT;
      S_M_WAIT: state_d = MOC ? (op_is_load_q ? S_WBACK : nxt) : expired ? S_ERROR : S_M_WAIT;
      default:  state_d = S_ERROR;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_is_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_is_load_q <= op_is_load_d;
    end
  end
  assign MFA     = in_wait;
  assign RW      = (state_q == S_F_WAIT || (state_q == S_M_WAIT && op_is_load_q)) ? RW_READ : RW_WRITE;
  assign IRLd    = state_q == S_F_WAIT && MOC;
  assign pc_inc  = IRLd;
  assign MARLd   = state_q == S_F_ADDR || state_q == S_M_ADDR;
  assign mar_sel = state_q == S_M_ADDR ? MAR_ALU : MAR_PC;
  assign MDRLd   = (state_q == S_M_ADDR && !op_is_load_q) || (state_q == S_M_WAIT && MOC && op_is_load_q);
  assign mdr_sel = (state_q == S_M_ADDR && !op_is_load_q) ? MDR_RF : MDR_MEM;
  assign rf_we   = state_q == S_EXEC || state_q == S_WBACK;
  assign FDRLd   = state_q == S_EXEC && s_bit;
  assign busy    = state_q != S_IDLE && state_q != S_ERROR;
  assign err     = state_q == S_ERROR;
endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// tb_cpu_mem_sequencer: directed self-checking bench for cpu_mem_sequencer with TIMEOUT=4
module tb_cpu_mem_sequencer;
  logic CLK = 1'b0, RST, start, is_load, is_store, cond_pass, s_bit, MOC;
  logic MFA, RW, IRLd, MARLd, MDRLd, FDRLd, mar_sel, mdr_sel, pc_inc, rf_we, busy, err;
  logic [11:0] outs, exp_v;
  int checks = 0, errors = 0;
  // {MFA,RW,IRLd,MARLd,MDRLd,FDRLd,mar_sel,mdr_sel,pc_inc,rf_we,busy,err}
  localparam logic [11:0] O_IDLE   = 12'b0000_0000_0000;
  localparam logic [11:0] O_FADDR  = 12'b0001_0000_0010;
  localparam logic [11:0] O_FWAIT  = 12'b1100_0000_0010;
  localparam logic [11:0] O_FMOC   = 12'b1110_0000_1010;
  localparam logic [11:0] O_DEC    = 12'b0000_0000_0010;
  localparam logic [11:0] O_EXEC_S = 12'b0000_0100_0110;
  localparam logic [11:0] O_MA_LD  = 12'b0001_0010_0010;
  localparam logic [11:0] O_MA_ST  = 12'b0001_1011_0010;
  localparam logic [11:0] O_MW_LD  = 12'b1100_0000_0010;
  localparam logic [11:0] O_MW_LDM = 12'b1100_1000_0010;
  localparam logic [11:0] O_MW_ST  = 12'b1000_0000_0010;
  localparam logic [11:0] O_WBACK  = 12'b0000_0000_0110;
  localparam logic [11:0] O_ERR    = 12'b0000_0000_0001;
  assign outs = {MFA, RW, IRLd, MARLd, MDRLd, FDRLd, mar_sel, mdr_sel, pc_inc, rf_we, busy, err};

  cpu_mem_sequencer #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .is_load(is_load), .is_store(is_store),
    .cond_pass(cond_pass), .s_bit(s_bit), .MOC(MOC), .MFA(MFA), .RW(RW), .IRLd(IRLd),
    .MARLd(MARLd), .MDRLd(MDRLd), .FDRLd(FDRLd), .mar_sel(mar_sel), .mdr_sel(mdr_sel),
    .pc_inc(pc_inc), .rf_we(rf_we), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic to_idle();
    tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; cond_pass = 1'b0;
    tick(); cond_pass = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; cond_pass = 1'b1; s_bit = 1'b0; MOC = 1'b0;
    tick(); tick(); RST = 1'b0; #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outs, exp_v); end
    MOC = 1'b1; tick(); MOC = 1'b0; #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL idle_moc_ignored got=%b exp=%b", outs, exp_v); end
  endtask

  task automatic test_alu();
    start = 1'b1; tick(); #1;
    exp_v = O_FADDR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_c1_faddr got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b1; #1;
    exp_v = O_FMOC; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_c2_fwait got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b0; cond_pass = 1'b1; #1;
    exp_v = O_DEC; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_c3_decode got=%b exp=%b", outs, exp_v); end
    tick(); s_bit = 1'b1; #1;
    exp_v = O_EXEC_S; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_c4_exec got=%b exp=%b", outs, exp_v); end
    tick(); s_bit = 1'b0; #1;
    exp_v = O_FADDR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_c5_back_to_back got=%b exp=%b", outs, exp_v); end
    start = 1'b0; to_idle(); #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL alu_stop_idle got=%b exp=%b", outs, exp_v); end
  endtask

  task automatic test_load();
    start = 1'b1; tick(); tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; is_load = 1'b1; start = 1'b0;
    tick(); is_load = 1'b0; #1;
    exp_v = O_MA_LD; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL load_maddr got=%b exp=%b", outs, exp_v); end
    for (int i = 1; i <= 2; i++) begin
      tick(); #1;
      exp_v = O_MW_LD; checks++;
      if (outs !== exp_v) begin errors++; $display("FAIL load_mwait_%0d got=%b exp=%b", i, outs, exp_v); end
    end
    tick(); MOC = 1'b1; #1;
    exp_v = O_MW_LDM; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL load_mwait_moc got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b0; #1;
    exp_v = O_WBACK; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL load_wback got=%b exp=%b", outs, exp_v); end
    tick(); #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL load_then_idle got=%b exp=%b", outs, exp_v); end
  endtask

  task automatic test_store();
    start = 1'b1; tick(); tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; is_store = 1'b1;
    tick(); is_store = 1'b0; #1;
    exp_v = O_MA_ST; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL store_maddr got=%b exp=%b", outs, exp_v); end
    tick(); #1;
    exp_v = O_MW_ST; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL store_mwait got=%b exp=%b", outs, exp_v); end
    MOC = 1'b1; #1;
    exp_v = O_MW_ST; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL store_mwait_moc got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b0; #1;
    exp_v = O_FADDR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL store_c6_faddr got=%b exp=%b", outs, exp_v); end
    start = 1'b0; to_idle();
  endtask

  task automatic test_load_and_store();
    start = 1'b1; tick(); tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; is_load = 1'b1; is_store = 1'b1; start = 1'b0;
    tick(); is_load = 1'b0; is_store = 1'b0; #1;
    exp_v = O_MA_LD; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL both_as_load_maddr got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b1; #1;
    exp_v = O_MW_LDM; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL both_as_load_mwait got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b0; tick();
  endtask

  task automatic test_skip();
    start = 1'b1; tick(); tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; cond_pass = 1'b0; is_load = 1'b1; s_bit = 1'b1; #1;
    exp_v = O_DEC; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL skip_decode got=%b exp=%b", outs, exp_v); end
    tick(); cond_pass = 1'b1; is_load = 1'b0; s_bit = 1'b0; #1;
    exp_v = O_FADDR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL skip_c4_faddr got=%b exp=%b", outs, exp_v); end
    start = 1'b0; to_idle();
  endtask

  task automatic test_moc_at_limit();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    tick(); #1;
    exp_v = O_FWAIT; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL limit_wait3 got=%b exp=%b", outs, exp_v); end
    MOC = 1'b1; #1;
    exp_v = O_FMOC; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL limit_wait4_moc got=%b exp=%b", outs, exp_v); end
    tick(); MOC = 1'b0; cond_pass = 1'b0; #1;
    exp_v = O_DEC; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL limit_decode_no_err got=%b exp=%b", outs, exp_v); end
    tick(); cond_pass = 1'b1;
  endtask

  task automatic test_timeout();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    tick(); #1;
    exp_v = O_FWAIT; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL timeout_wait4 got=%b exp=%b", outs, exp_v); end
    tick(); #1;
    exp_v = O_ERR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL timeout_err got=%b exp=%b", outs, exp_v); end
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      MOC = (i == 5);
      tick(); #1;
      exp_v = O_ERR; checks++;
      if (outs !== exp_v) begin errors++; $display("FAIL timeout_sticky_%0d got=%b exp=%b", i, outs, exp_v); end
    end
    MOC = 1'b0; start = 1'b0;
  endtask

  task automatic test_rst_mid();
    RST = 1'b1; tick(); RST = 1'b0; #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL rst_from_error got=%b exp=%b", outs, exp_v); end
    start = 1'b1; tick(); tick(); MOC = 1'b1;
    tick(); MOC = 1'b0; is_load = 1'b1;
    tick(); is_load = 1'b0;
    tick(); #1;
    exp_v = O_MW_LD; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL rst_pre_mwait got=%b exp=%b", outs, exp_v); end
    RST = 1'b1; tick(); RST = 1'b0; start = 1'b0; #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL rst_mid_idle got=%b exp=%b", outs, exp_v); end
    MOC = 1'b1; tick(); MOC = 1'b0; #1;
    exp_v = O_IDLE; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL rst_moc_ignored got=%b exp=%b", outs, exp_v); end
    start = 1'b1; tick(); start = 1'b0; #1;
    exp_v = O_FADDR; checks++;
    if (outs !== exp_v) begin errors++; $display("FAIL rst_restart_faddr got=%b exp=%b", outs, exp_v); end
    to_idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_load_and_store();
    test_skip();
    test_moc_at_limit();
    test_timeout();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
